mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 119 +++++++++++
 tb/tb_mem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Shared-memory access controller for the fetch and data ports.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mem_access_ctrl #(
  parameter int LATENCY = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [`WORD_SIZE-1:0]   d_addr,
  input  logic [`WORD_SIZE-1:0]   d_wdata,
  output logic [`WORD_SIZE-1:0]   d_rdata,
  output logic                    d_done,
  input  logic                    i_req,
  input  logic [`WORD_SIZE-1:0]   i_addr,
  output logic [`WORD_SIZE-1:0]   i_rdata,
  output logic                    i_done,
  output logic                    stall_d,
  output logic                    stall_i,
  output logic                    mem_we,
  output logic [`WORD_SIZE-1:0]   mem_addr,
  output logic [`WORD_SIZE-1:0]   mem_wdata,
  input  logic [`WORD_SIZE-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [3:0]            cnt;
  logic                  grantI;
  logic                  latWe;
  logic [`WORD_SIZE-1:0] latAddr;
  logic [`WORD_SIZE-1:0] latWdata;
  logic [`WORD_SIZE-1:0] dRdata;
  logic [`WORD_SIZE-1:0] iRdata;
  logic                  pickI;
  logic                  anyReq;
  logic                  inAccess;
  logic                  lastBeat;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the instruction side held the most recent grant.
  logic lastGrantI;
  assign pickI = i_req & (~d_req | ~lastGrantI);
`else
  assign pickI = i_req & ~d_req;
`endif

  assign anyReq   = d_req | i_req;
  assign inAccess = (state == ACCESS);
  assign lastBeat = inAccess && (cnt == 4'd0);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (cnt == 4'd0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      grantI   <= 1'b0;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      dRdata   <= '0;
      iRdata   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastGrantI <= 1'b1;
`endif
    end else begin
      state <= stateNext;
      if (state == IDLE && anyReq) begin
        grantI   <= pickI;
        latAddr  <= pickI ? i_addr : d_addr;
        latWdata <= pickI ? '0 : d_wdata;
        latWe    <= ~pickI & d_we;
        cnt      <= 4'(LATENCY - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        lastGrantI <= pickI;
`endif
      end else if (inAccess) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (grantI) begin
          iRdata <= mem_rdata;
        end else if (!latWe) begin
          dRdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = inAccess ? latAddr : '0;
  assign mem_wdata = inAccess ? latWdata : '0;
  assign mem_we    = lastBeat && latWe && !rst;

  assign d_done  = (state == DONE) && !grantI;
  assign i_done  = (state == DONE) && grantI;
  assign d_rdata = dRdata;
  assign i_rdata = iRdata;
  assign stall_d = d_req && !d_done;
  assign stall_i = i_req && !i_done;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: phase-indexed reference model plus
// directed scenarios with literal expectations.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_mem_access_ctrl;
  localparam int L = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        i_req, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        stall_d, stall_i, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        d_req1, d_done1, i_done1;
  logic        stall_d1, stall_i1, mem_we1;
  logic [31:0] d_addr1, d_rdata1, i_rdata1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  logic [31:0] tbMem  [0:255];
  logic [31:0] refMem [0:255];

  assign mem_rdata  = tbMem[mem_addr[9:2]];
  assign mem_rdata1 = tbMem[mem_addr1[9:2]];

  always @(posedge clk)
    if (mem_we) tbMem[mem_addr[9:2]] <= mem_wdata;

  mem_access_ctrl #(.LATENCY(L)) u0 (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_done(i_done),
    .stall_d(stall_d), .stall_i(stall_i),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1),
    .d_wdata(32'h0), .d_rdata(d_rdata1), .d_done(d_done1),
    .i_req(1'b0), .i_addr(32'h0),
    .i_rdata(i_rdata1), .i_done(i_done1),
    .stall_d(stall_d1), .stall_i(stall_i1),
    .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int weCount = 0;
  int doneCount = 0;
  logic checkEn = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (checkEn && mem_we) weCount++;
    if (checkEn && (d_done || i_done)) doneCount++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic chkBit(input string name, input logic act,
                        input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: k counts cycles since the grant
  // (0 idle, 1..L memory busy, L+1 completion).
  int          k = 0;
  logic        mPortI = 1'b0;
  logic        mWe = 1'b0;
  logic        lastI = 1'b1;
  logic [31:0] mAddr = '0, mWdata = '0, expD = '0, expI = '0;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; mPortI = 1'b0; mWe = 1'b0; lastI = 1'b1;
      mAddr = '0; mWdata = '0; expD = '0; expI = '0;
    end else if (k == 0) begin
      if (d_req || i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        mPortI = i_req && (!d_req || !lastI);
`else
        mPortI = !d_req;
`endif
        lastI  = mPortI;
        mAddr  = mPortI ? i_addr : d_addr;
        mWdata = mPortI ? 32'h0 : d_wdata;
        mWe    = !mPortI && d_we;
        k = 1;
      end
    end else if (k == L) begin
      if (mWe) refMem[mAddr[9:2]] = mWdata;
      else if (mPortI) expI = refMem[mAddr[9:2]];
      else expD = refMem[mAddr[9:2]];
      k = L + 1;
    end else if (k == L + 1) begin
      k = 0;
    end else begin
      k++;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      logic acc, dn;
      acc = (k >= 1) && (k <= L);
      dn  = (k == L + 1);
      chk("mem_addr", mem_addr, acc ? mAddr : 32'h0);
      chk("mem_wdata", mem_wdata, acc ? mWdata : 32'h0);
      chkBit("mem_we", mem_we, acc && (k == L) && mWe && !rst);
      chkBit("d_done", d_done, dn && !mPortI);
      chkBit("i_done", i_done, dn && mPortI);
      chk("d_rdata", d_rdata, expD);
      chk("i_rdata", i_rdata, expI);
      chkBit("stall_d", stall_d, d_req && !(dn && !mPortI));
      chkBit("stall_i", stall_i, i_req && !(dn && mPortI));
    end
  end

  task automatic waitDone(input logic isI, output int at);
    logic found;
    found = 1'b0;
    at = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (isI ? i_done : d_done) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: port %0d got no done, expected one",
               isI);
    end
    @(posedge clk); #1;
    if (isI) i_req = 1'b0;
    else begin d_req = 1'b0; d_we = 1'b0; end
  endtask

  task automatic dAccess(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
    int s0, at;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    s0 = cyc;
    waitDone(1'b0, at);
    lat = at - s0;
  endtask

  initial begin
    int lat, dCyc, iCyc, n, snapWe, snapDone;
    logic order [0:3];
    for (int i = 0; i < 256; i++) begin
      tbMem[i]  = 32'hC0DE0000 | 32'(i);
      refMem[i] = 32'hC0DE0000 | 32'(i);
    end
    tbMem[4]   = 32'hDEADBEEF; refMem[4]  = 32'hDEADBEEF;
    tbMem[12]  = 32'hA5A5A5A5; refMem[12] = 32'hA5A5A5A5;
    rst = 1'b1;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; d_req1 = 0; d_addr1 = 0;
    @(posedge clk); #1;
    checkEn = 1'b1;
    @(posedge clk); #1;
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;

    dAccess(1'b0, 32'h10, 32'h0, lat);
    chk("load_latency", lat, 32'd6);
    chk("load_data", d_rdata, 32'hDEADBEEF);

    snapWe = weCount;
    dAccess(1'b1, 32'h20, 32'h12345678, lat);
    chk("store_latency", lat, 32'd6);
    chk("store_we_count", weCount - snapWe, 32'd1);
    dAccess(1'b0, 32'h20, 32'h0, lat);
    chk("store_readback", d_rdata, 32'h12345678);

    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    i_req = 1'b1; i_addr = 32'h20;
    fork
      waitDone(1'b0, dCyc);
      waitDone(1'b1, iCyc);
    join
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_gap_i_first", dCyc - iCyc, 32'd7);
`else
    chk("tie_gap_d_first", iCyc - dCyc, 32'd7);
`endif
    chk("tie_i_rdata", i_rdata, 32'h12345678);

    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    d_req = 1'b1; d_addr = 32'h10; i_req = 1'b1; i_addr = 32'h14;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (d_done) begin order[n] = 1'b0; n++; end
      else if (i_done) begin order[n] = 1'b1; n++; end
    end
    @(posedge clk); #1; d_req = 1'b0; i_req = 1'b0;
    chk("stream_grants", n, 32'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chkBit("stream_g0", order[0], 1'b0);
    chkBit("stream_g1", order[1], 1'b1);
    chkBit("stream_g2", order[2], 1'b0);
    chkBit("stream_g3", order[3], 1'b1);
`else
    chkBit("stream_g0", order[0], 1'b0);
    chkBit("stream_g1", order[1], 1'b0);
    chkBit("stream_g2", order[2], 1'b0);
    chkBit("stream_g3", order[3], 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1; snapWe = weCount; snapDone = doneCount;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h11112222;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort_mem_addr", mem_addr, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_we", weCount - snapWe, 32'd0);
    chk("abort_no_done", doneCount - snapDone, 32'd0);
    chk("abort_mem_word", tbMem[12], 32'hA5A5A5A5);

    d_req1 = 1'b1; d_addr1 = 32'h10;
    @(posedge clk); #1;
    d_addr1 = 32'h40;
    @(negedge clk);
    chkBit("l1_no_done_yet", d_done1, 1'b0);
    chkBit("l1_stall", stall_d1, 1'b1);
    chk("l1_mem_addr", mem_addr1, 32'h10);
    @(negedge clk);
    chkBit("l1_done", d_done1, 1'b1);
    chkBit("l1_stall_done", stall_d1, 1'b0);
    chk("l1_data", d_rdata1, 32'hDEADBEEF);
    chkBit("l1_i_done", i_done1, 1'b0);
    chkBit("l1_stall_i", stall_i1, 1'b0);
    chkBit("l1_mem_we", mem_we1, 1'b0);
    chk("l1_mem_wdata", mem_wdata1, 32'h0);
    chk("l1_i_rdata", i_rdata1, 32'h0);
    @(posedge clk); #1; d_req1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
